// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath.
// Optional macro BNE_EN adds a branch-not-equal state (BNE = 12).
module multicycle_control (
  input  logic       CLK,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11,
    BNE      = 4'd12
  } state_e;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  state_e state_q, state_d;
  logic   run_q;
  logic   pc_write, branch, branch_ne;

  // run_q holds the FSM in FETCH for the first edge after reset release.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      run_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (run_q) state_q <= state_d;
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
`ifdef BNE_EN
          OP_BNE:       state_d = BNE;
`endif
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      EXECUTE:  state_d = ALUWB;
      ADDIEXEC: state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase
  end

  // Outputs are gated by rst so they clear asynchronously with the reset.
  always_comb begin
    IorD      = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    PCSrc     = 2'b00;
    pc_write  = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    if (rst) begin
      case (state_q)
        FETCH:    begin IRWrite = 1'b1; ALUSrcB = 2'b01; pc_write = 1'b1; end
        DECODE:   ALUSrcB = 2'b11;
        MEMADR:   begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        MEMRD:    IorD = 1'b1;
        MEMWB:    begin RegWrite = 1'b1; MemtoReg = 1'b1; end
        MEMWR:    begin IorD = 1'b1; MemWrite = 1'b1; end
        EXECUTE:  begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
        ALUWB:    begin RegDst = 1'b1; RegWrite = 1'b1; end
        BRANCH:   begin ALUSrcA = 1'b1; ALUOp = 2'b01; PCSrc = 2'b01; branch = 1'b1; end
        ADDIEXEC: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        ADDIWB:   RegWrite = 1'b1;
        JUMP:     begin PCSrc = 2'b10; pc_write = 1'b1; end
`ifdef BNE_EN
        BNE:      begin ALUSrcA = 1'b1; ALUOp = 2'b01; PCSrc = 2'b01; branch_ne = 1'b1; end
`endif
        default:  ;
      endcase
    end
    PCEn = pc_write | (branch & Zero) | (branch_ne & ~Zero);
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level path model feeds a queue
// of expected per-cycle outputs; a negedge monitor pops and compares.
module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       rst;
  logic [5:0] Op;
  logic       Zero;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;
  logic [17:0] exp_q[$];
  logic [17:0] dut_vec;

  always #5 CLK = ~CLK;

  multicycle_control dut (
    .CLK(CLK), .rst(rst), .Op(Op), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn), .state(state)
  );

  assign dut_vec = {state, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                    ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn};

  // Instruction latency table.
  function automatic int path_len(input logic [5:0] op);
    case (op)
      6'b100011:                      return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010:           return 3;
`ifdef BNE_EN
      6'b000101:                      return 3;
`endif
      default:                        return 2;
    endcase
  endfunction

  // State visited at cycle idx of an instruction.
  function automatic int path_state(input logic [5:0] op, input int idx);
    if (idx == 0) return 0;
    if (idx == 1) return 1;
    case (op)
      6'b100011: return (idx == 2) ? 2 : (idx == 3) ? 3 : 4;
      6'b101011: return (idx == 2) ? 2 : 5;
      6'b000000: return (idx == 2) ? 6 : 7;
      6'b001000: return (idx == 2) ? 9 : 10;
      6'b000100: return 8;
      6'b000010: return 11;
      6'b000101: return 12;
      default:   return 0;
    endcase
  endfunction

  function automatic logic [17:0] expect_vec(input int st, input logic z, input logic r);
    logic [3:0] s;
    logic iord, mw, irw, rd, m2r, rw, asa, pcw, br, bne;
    logic [1:0] asb, aop, pcs;
    s = st[3:0];
    {iord, mw, irw, rd, m2r, rw, asa, pcw, br, bne} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    if (!r) return 18'd0;
    case (st)
      0:  begin irw = 1; asb = 2'b01; pcw = 1; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  iord = 1;
      4:  begin rw = 1; m2r = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcw = 1; end
      12: begin asa = 1; aop = 2'b01; pcs = 2'b01; bne = 1; end
      default: ;
    endcase
    return {s, iord, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, pcw | (br & z) | (bne & ~z)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] op, input int st, input int zmode);
    @(posedge CLK);
    #1;
    rst  = r;
    Op   = op;
    Zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
    exp_q.push_back(expect_vec(st, Zero, r));
  endtask

  task automatic run_instr(input logic [5:0] op, input int zmode);
    for (int i = 0; i < path_len(op); i++) step(1'b1, op, path_state(op, i), zmode);
  endtask

  task automatic reset_and_release(input logic [5:0] first_op);
    step(1'b0, first_op, 0, -1);
    step(1'b1, first_op, 0, -1);
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      logic [17:0] e;
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL cycle exp_state=%0d got=%h want=%h", e[17:14], dut_vec, e);
      end
    end
  end

  initial begin
    logic [5:0] ops [8];
    logic [5:0] op;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
            6'b001000, 6'b000010, 6'b000101, 6'b111111};
    rst = 1'b0; Op = 6'd0; Zero = 1'b0;
    repeat (3) step(1'b0, 6'd0, 0, -1);
    step(1'b1, 6'b100011, 0, -1);

    run_instr(6'b100011, -1);
    run_instr(6'b000100, 1);
    run_instr(6'b000100, 0);
    run_instr(6'b111111, -1);
    run_instr(6'b000101, 0);
    run_instr(6'b000000, -1);
    run_instr(6'b001000, -1);
    run_instr(6'b000010, -1);
    run_instr(6'b101011, -1);

    // Reset in the middle of a store, while MemWrite is high.
    for (int i = 0; i < 3; i++) step(1'b1, 6'b101011, path_state(6'b101011, i), -1);
    @(posedge CLK);
    #1;
    Zero = 1'b0;
    chk("memwr_before_rst", {31'd0, MemWrite}, 32'd1);
    chk("state_before_rst", {28'd0, state}, 32'd5);
    rst = 1'b0;
    #1;
    chk("memwr_after_rst", {31'd0, MemWrite}, 32'd0);
    chk("state_after_rst", {28'd0, state}, 32'd0);
    exp_q.push_back(18'd0);
    reset_and_release(6'b100011);

    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)];
      run_instr(op, -1);
      if ($urandom_range(0, 15) == 0) reset_and_release(6'b000000);
    end

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge CLK);
    @(negedge CLK);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain remaining=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; state encoding is fixed by REQ-011.
REQ-002 CLK  input  1  single clock; all state updates occur on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; 0 resets the block immediately.
REQ-004 Op  input  6  opcode field taken from the instruction register.
REQ-005 Zero  input  1  ALU zero flag from the branch-compare cycle.
REQ-006 IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA  output  1 each  datapath mux and write enables.
REQ-007 ALUSrcB  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
REQ-008 ALUOp  output  2  ALU decoder hint: 00 = add, 01 = subtract, 10 = use funct field.
REQ-009 PCSrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-010 PCEn  output  1  PC register load enable; state  output  4  current state, for debug.

Function
REQ-011 Moore FSM; state encodings:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
- EXECUTE = 6, ALUWB = 7, BRANCH = 8, ADDIEXEC = 9, ADDIWB = 10, JUMP = 11
REQ-012 Transitions:
- FETCH -> DECODE
- DECODE -> by Op: MEMADR for lw 100011 or sw 101011; EXECUTE for 000000; BRANCH for beq 000100; ADDIEXEC for 001000; JUMP for 000010
- MEMADR -> MEMRD for lw, MEMWR for sw
- MEMRD -> MEMWB; EXECUTE -> ALUWB; ADDIEXEC -> ADDIWB
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH
REQ-013 In DECODE, any unlisted opcode returns to FETCH with no write enable asserted.
REQ-014 MEMADR branches on Op as registered in the instruction register; Op is stable after FETCH.
REQ-015 Per-state outputs (every output not listed is 0):
- FETCH: IRWrite = 1, ALUSrcB = 01, PCWrite = 1
- DECODE: ALUSrcB = 11
- MEMADR: ALUSrcA = 1, ALUSrcB = 10
- MEMRD: IorD = 1
- MEMWB: RegWrite = 1, MemtoReg = 1
- MEMWR: IorD = 1, MemWrite = 1
- EXECUTE: ALUSrcA = 1, ALUOp = 10
- ALUWB: RegDst = 1, RegWrite = 1
- BRANCH: ALUSrcA = 1, ALUOp = 01, PCSrc = 01, Branch = 1
- ADDIEXEC: ALUSrcA = 1, ALUSrcB = 10
- ADDIWB: RegWrite = 1
- JUMP: PCSrc = 10, PCWrite = 1
REQ-016 PCEn = PCWrite OR (Branch AND Zero), computed combinationally in the same cycle as Zero.
REQ-017 Instruction latency in cycles:
- lw: 5
- sw, R-type, addi: 4
- beq, j: 3
- illegal opcode: 2
REQ-018 PCWrite, Branch and BranchNE are internal only; they SHALL NOT appear as ports.

Reset
REQ-019 While rst = 0, state = FETCH and every output, including PCEn, is forced to 0 asynchronously.
REQ-020 On the first rising CLK edge after rst rises, the block does not advance; FETCH outputs are presented during that cycle (PCEn = 1).
REQ-021 Reset asserted mid-instruction aborts it; no write enable remains asserted after rst falls.

Configuration
REQ-022 Macro BNE_EN, when defined:
- opcode 000101 decodes in DECODE to state BNE = 12
- BNE drives the BRANCH outputs, except internal BranchNE = 1 in place of Branch
- BNE -> FETCH
- PCEn additionally ORs in (BranchNE AND NOT Zero)
REQ-023 Without BNE_EN, opcode 000101 is treated as illegal (REQ-013), and state 12 is never reached.

Verification
REQ-024 Reset: rst = 0 for 3 cycles -> all outputs 0 and state = 0; after rst rises, IRWrite = 1, PCEn = 1, ALUSrcB = 01.
REQ-025 lw: Op = 100011 -> state sequence 0, 1, 2, 3, 4, 0; RegWrite = 1 and MemtoReg = 1 only in state 4.
REQ-026 beq: Op = 000100 with Zero = 1 -> PCEn = 1 and PCSrc = 01 in state 8; repeated with Zero = 0 -> PCEn = 0 in state 8.
REQ-027 Illegal opcode: Op = 111111 -> state sequence 0, 1, 0; RegWrite and MemWrite never asserted.
REQ-028 Mid-instruction reset: rst = 0 during MEMWR -> MemWrite drops to 0 within the same cycle; state = 0.
REQ-029 BNE_EN defined: Op = 000101 with Zero = 0 -> state 12 and PCEn = 1; without BNE_EN, Op = 000101 -> state sequence 0, 1, 0.
